// File: rtl/bcd_pkg.sv
// Shared types, defaults and helpers for the cascaded BCD counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Time-of-day defaults: HH:MM:SS with hours capped at 23.
    localparam int                 TOD_DIGITS = 6;
    localparam logic [4*6-1:0]     TOD_LIMITS = {4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};
    localparam logic [4*6-1:0]     TOD_WRAP   = 24'h235959;

    // Saturate a loaded digit to its limit (also catches A-F).
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t digit, input bcd_digit_t limit);
        return (digit > limit) ? limit : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: load/clamp, up/down step with rollover at a per-digit limit,
// and a combinational carry/borrow to the next digit.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [3:0] cur_i,
    input  logic [3:0] limit_i,
    input  logic       step_i,
    input  logic       dir_i,
    input  logic       load_i,
    input  logic [3:0] load_digit_i,
    output logic [3:0] next_o,
    output logic       carry_o,
    output logic       clamp_o
);

    logic at_edge;
    logic up;

    assign up      = (dir_e'(dir_i) == DIR_UP);
    // Rollover point: limit when counting up, zero when counting down.
    assign at_edge = up ? (cur_i == limit_i) : (cur_i == 4'd0);
    assign carry_o = step_i & at_edge;
    assign clamp_o = (load_digit_i > limit_i);

    // Next digit value: load wins, then step, else hold.
    always_comb begin
        next_o = cur_i;
        if (load_i) begin
            next_o = bcd_clamp(load_digit_i, limit_i);
        end else if (step_i) begin
            if (up) next_o = at_edge ? 4'd0    : cur_i + 4'd1;
            else    next_o = at_edge ? limit_i : cur_i - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_chain_counter.sv
// Multi-digit cascaded BCD up/down counter with per-digit limits, optional
// whole-value wrap point, clamped parallel load and registered status pulses.
module bcd_chain_counter
    import bcd_pkg::*;
#(
    parameter int                        NUM_DIGITS   = TOD_DIGITS,
    parameter logic [4*NUM_DIGITS-1:0]   DIGIT_LIMITS = TOD_LIMITS,
    parameter bit                        WRAP_EN      = 1'b1,
    parameter logic [4*NUM_DIGITS-1:0]   WRAP_VAL     = TOD_WRAP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick_in,
    input  logic                      dir,
    input  logic                      load_enable,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic                      wrap_out,
    output logic                      load_err
);

    logic [4*NUM_DIGITS-1:0] count_q, count_d, cell_next;
    logic                    wrap_q, wrap_d;
    logic                    load_err_q, load_err_d;
    logic [NUM_DIGITS:0]     step;
    logic [NUM_DIGITS-1:0]   clamp;
    logic                    force_zero, force_wrap_val;

    // A load suppresses any step so carries never interfere with loaded data.
    assign step[0] = tick_in & ~load_enable;

    genvar g;
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
        if (DIGIT_LIMITS[4*g +: 4] < 4'd1 || DIGIT_LIMITS[4*g +: 4] > 4'd9) begin : g_bad_limit
            $error("bcd_chain_counter: digit %0d limit out of 1..9", g);
        end
        if (WRAP_EN && (WRAP_VAL[4*g +: 4] > DIGIT_LIMITS[4*g +: 4])) begin : g_bad_wrap
            $error("bcd_chain_counter: WRAP_VAL digit %0d exceeds its limit", g);
        end

        bcd_digit_cell u_cell (
            .cur_i        (count_q[4*g +: 4]),
            .limit_i      (DIGIT_LIMITS[4*g +: 4]),
            .step_i       (step[g]),
            .dir_i        (dir),
            .load_i       (load_enable),
            .load_digit_i (load_val[4*g +: 4]),
            .next_o       (cell_next[4*g +: 4]),
            .carry_o      (step[g+1]),
            .clamp_o      (clamp[g])
        );
    end

    // Whole-value wrap overrides: up from WRAP_VAL goes to 0; down from 0 goes
    // to WRAP_VAL. Values above WRAP_VAL fall through to natural rollover.
    assign force_zero     = WRAP_EN && step[0] && dir && (count_q == WRAP_VAL);
    assign force_wrap_val = WRAP_EN && step[NUM_DIGITS] && !dir;

    // Next-state for count and the status pulses.
    always_comb begin
        count_d = cell_next;
        if (force_zero)     count_d = '0;
        if (force_wrap_val) count_d = WRAP_VAL;
        wrap_d     = step[NUM_DIGITS] | force_zero;
        load_err_d = load_enable & (|clamp);
    end

    // Registered state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap_out = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed bench for bcd_chain_counter: a time-of-day build (WRAP_EN=1) and a
// natural-wrap build (WRAP_EN=0) share the same stimulus.
module tb_bcd_chain_counter;

    logic        clk = 1'b0;
    logic        rst_n, tick_in, dir, load_enable;
    logic [23:0] load_val;
    logic [23:0] count, count2;
    logic        wrap_out, wrap2, load_err, err2;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    bcd_chain_counter #(.NUM_DIGITS(6), .DIGIT_LIMITS({4'd2,4'd9,4'd5,4'd9,4'd5,4'd9}),
                        .WRAP_EN(1'b1), .WRAP_VAL(24'h235959)) dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .dir(dir),
        .load_enable(load_enable), .load_val(load_val),
        .count(count), .wrap_out(wrap_out), .load_err(load_err));

    bcd_chain_counter #(.NUM_DIGITS(6), .DIGIT_LIMITS({4'd2,4'd9,4'd5,4'd9,4'd5,4'd9}),
                        .WRAP_EN(1'b0), .WRAP_VAL(24'h235959)) dut_nw (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .dir(dir),
        .load_enable(load_enable), .load_val(load_val),
        .count(count2), .wrap_out(wrap2), .load_err(err2));

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic ld, input logic [23:0] lv, input logic tk, input logic d);
        load_enable = ld; load_val = lv; tick_in = tk; dir = d;
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [23:0] c_exp, input logic w_exp, input logic e_exp);
        n_checks++;
        if (count !== c_exp || wrap_out !== w_exp || load_err !== e_exp) begin
            n_err++;
            $display("FAIL %s: count=%h wrap=%b err=%b, expected count=%h wrap=%b err=%b",
                     name, count, wrap_out, load_err, c_exp, w_exp, e_exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        cyc(1, 24'h123456, 0, 1);
        chk("reset_preload", 24'h123456, 0, 0);
        rst_n = 1'b0;
        cyc(0, 24'h0, 1, 1);
        chk("reset_edge1", 24'h0, 0, 0);
        n_checks++;
        if (count2 !== 24'h0 || wrap2 !== 1'b0 || err2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_nw: count=%h wrap=%b err=%b, expected 000000/0/0", count2, wrap2, err2);
        end
        cyc(0, 24'h0, 1, 1);
        chk("reset_edge2", 24'h0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 24'h0, 0, 1);
        chk("reset_release_hold", 24'h0, 0, 0);
    endtask

    task automatic test_up_wrap();
        cyc(1, 24'h235958, 0, 1);
        chk("up_load", 24'h235958, 0, 0);
        cyc(0, 24'h0, 1, 1);
        chk("up_tick1", 24'h235959, 0, 0);
        cyc(0, 24'h0, 1, 1);
        chk("up_wrap", 24'h000000, 1, 0);
        cyc(0, 24'h0, 0, 1);
        chk("up_wrap_pulse_end", 24'h000000, 0, 0);
    endtask

    task automatic test_carry();
        cyc(1, 24'h095959, 0, 1);
        cyc(0, 24'h0, 1, 1);
        chk("full_carry", 24'h100000, 0, 0);
    endtask

    task automatic test_down_wrap();
        cyc(1, 24'h000000, 0, 0);
        cyc(0, 24'h0, 1, 0);
        chk("down_wrap", 24'h235959, 1, 0);
        cyc(0, 24'h0, 1, 0);
        chk("down_after_wrap", 24'h235958, 0, 0);
    endtask

    task automatic test_clamp();
        cyc(1, 24'h1F7959, 0, 1);
        chk("clamp_load", 24'h195959, 0, 1);
        cyc(0, 24'h0, 0, 1);
        chk("clamp_pulse_end", 24'h195959, 0, 0);
        cyc(1, 24'h12345A, 0, 1);
        chk("clamp_digit0", 24'h123459, 0, 1);
    endtask

    task automatic test_load_vs_tick();
        cyc(1, 24'h235959, 0, 1);
        cyc(1, 24'h000005, 1, 1);
        chk("load_beats_tick", 24'h000005, 0, 0);
    endtask

    task automatic test_dir_reversal();
        cyc(1, 24'h000100, 0, 1);
        cyc(0, 24'h0, 1, 1);
        chk("rev_up", 24'h000101, 0, 0);
        cyc(0, 24'h0, 1, 0);
        chk("rev_down1", 24'h000100, 0, 0);
        cyc(0, 24'h0, 1, 0);
        chk("rev_down_borrow", 24'h000059, 0, 0);
    endtask

    task automatic test_above_wrap();
        cyc(1, 24'h240000, 0, 1);
        cyc(0, 24'h0, 1, 1);
        chk("above_wrap_step", 24'h240001, 0, 0);
        cyc(1, 24'h295959, 0, 1);
        cyc(0, 24'h0, 1, 1);
        chk("above_wrap_natural", 24'h000000, 1, 0);
    endtask

    task automatic test_no_wrap_en();
        cyc(1, 24'h295959, 0, 1);
        cyc(0, 24'h0, 1, 1);
        n_checks++;
        if (count2 !== 24'h000000 || wrap2 !== 1'b1) begin
            n_err++;
            $display("FAIL nowrap_up: count=%h wrap=%b, expected 000000/1", count2, wrap2);
        end
        cyc(0, 24'h0, 1, 0);
        n_checks++;
        if (count2 !== 24'h295959 || wrap2 !== 1'b1) begin
            n_err++;
            $display("FAIL nowrap_down: count=%h wrap=%b, expected 295959/1", count2, wrap2);
        end
        cyc(0, 24'h0, 1, 1);
        n_checks++;
        if (count2 !== 24'h000000 || wrap2 !== 1'b1) begin
            n_err++;
            $display("FAIL nowrap_up2: count=%h wrap=%b, expected 000000/1", count2, wrap2);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick_in = 1'b0; dir = 1'b1; load_enable = 1'b0; load_val = '0;
        @(posedge clk); #1;
        test_reset();
        test_up_wrap();
        test_carry();
        test_down_wrap();
        test_clamp();
        test_load_vs_tick();
        test_dir_reversal();
        test_above_wrap();
        test_no_wrap_en();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
